// File: rtl/tetris_dp_param.sv
// tetris_dp_param: parametrised self-sequenced Tetris datapath.
// W x H locked board, 2x2 active piece, gravity timer, valid/ready move port,
// multi-row line clear. Optional cleared-lines counter under TETRIS_LINES_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// GEN      | load new piece at spawn; spawn collision ends the game
// MOVE     | accept moves, gravity timer running
// LAND     | OR active piece into locked board, touched pulse
// CLEAR    | remove one full row per cycle (lowest on screen first)
// NEWBOARD | empty board, wait for start
// GAMEOVER | board shown all ones until restart
module tetris_dp_param #(
  parameter int W          = 4,
  parameter int H          = 8,
  parameter int SPAWN_X    = 1,
  parameter int DROP_TICKS = 8,
  parameter int LINES_W    = 8
) (
  input  logic                   clka,
  input  logic                   restart,
  input  logic                   start,
  input  logic [1:0]             piece_in,
  input  logic                   move_valid,
  input  logic [1:0]             move,
  output logic                   move_ready,
  output logic [2:0]             state,
  output logic [W*H-1:0]         board_out,
  output logic [$clog2(W)-1:0]   location_x,
  output logic [$clog2(H)-1:0]   location_y,
  output logic [1:0]             rotation,
  output logic                   touched,
  output logic                   game_over,
  output logic [LINES_W-1:0]     lines
);
  localparam int N  = W * H;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int CW = $clog2(DROP_TICKS + 1);

  typedef enum logic [2:0] {
    GEN = 3'b000, MOVE = 3'b001, LAND = 3'b010,
    CLEAR = 3'b011, NEWBOARD = 3'b100, GAMEOVER = 3'b101
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    locked_q, locked_d;
  logic [3:0]      mask_q, mask_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [1:0]      rot_q, rot_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clr_found;
  logic [N-1:0]    clr_board;

  // mask bits: b0 TL, b1 TR, b2 BL, b3 BR
  function automatic logic [3:0] decode(input logic [1:0] p);
    case (p)
      2'd0:    return 4'b1111;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b0111;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [3:0] rot_cw(input logic [3:0] m);
    return {m[1], m[3], m[0], m[2]};
  endfunction

  function automatic logic [N-1:0] piece_bits(input logic [3:0] m, input int px, input int py);
    logic [N-1:0] b;
    int cx, cy;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      cx = px + (i % 2);
      cy = py + (i / 2);
      if (m[i] && cx >= 0 && cx < W && cy >= 0 && cy < H)
        b = b | (N'(1) << (cy * W + cx));
    end
    return b;
  endfunction

  function automatic logic collides(input logic [3:0] m, input int px, input int py,
                                    input logic [N-1:0] lk);
    logic hit;
    int cx, cy;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cx = px + (i % 2);
      cy = py + (i / 2);
      if (m[i] && (cx < 0 || cx >= W || cy < 0 || cy >= H)) hit = 1'b1;
    end
    if ((piece_bits(m, px, py) & lk) != '0) hit = 1'b1;
    return hit;
  endfunction

  // find the largest-index full row and build the board with it removed
  always_comb begin
    int idx;
    clr_found = 1'b0;
    idx = 0;
    for (int r = 0; r < H; r++) begin
      if (&locked_q[r*W +: W]) begin
        clr_found = 1'b1;
        idx = r;
      end
    end
    clr_board = locked_q;
    for (int r = 0; r < H; r++) begin
      if (r <= idx) begin
        if (r == 0) clr_board[0 +: W] = '0;
        else        clr_board[r*W +: W] = locked_q[(r-1)*W +: W];
      end
    end
  end

  // next-state logic for the game FSM and the piece/board registers
  always_comb begin
    logic do_drop;
    state_d  = state_q;
    locked_d = locked_q;
    mask_d   = mask_q;
    x_d      = x_q;
    y_d      = y_q;
    rot_d    = rot_q;
    cnt_d    = cnt_q;
    do_drop  = 1'b0;
    case (state_q)
      NEWBOARD: begin
        locked_d = '0;
        if (start) state_d = GEN;
      end
      GEN: begin
        mask_d = decode(piece_in);
        x_d    = XW'(SPAWN_X);
        y_d    = '0;
        rot_d  = '0;
        cnt_d  = '0;
        if (collides(decode(piece_in), SPAWN_X, 0, locked_q)) state_d = GAMEOVER;
        else                                                   state_d = MOVE;
      end
      MOVE: begin
        if (cnt_q == CW'(DROP_TICKS - 1)) begin
          do_drop = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (move_valid) begin
            case (move)
              2'd0: begin
                do_drop = 1'b1;
                cnt_d   = '0;
              end
              2'd1: if (x_q != '0 && !collides(mask_q, int'(x_q) - 1, int'(y_q), locked_q))
                      x_d = x_q - 1'b1;
              2'd2: if (!collides(mask_q, int'(x_q) + 1, int'(y_q), locked_q))
                      x_d = x_q + 1'b1;
              default: if (!collides(rot_cw(mask_q), int'(x_q), int'(y_q), locked_q)) begin
                      mask_d = rot_cw(mask_q);
                      rot_d  = rot_q + 1'b1;
                    end
            endcase
          end
        end
        if (do_drop) begin
          if (!collides(mask_q, int'(x_q), int'(y_q) + 1, locked_q)) y_d = y_q + 1'b1;
          else                                                       state_d = LAND;
        end
      end
      LAND: begin
        locked_d = locked_q | piece_bits(mask_q, int'(x_q), int'(y_q));
        state_d  = CLEAR;
      end
      CLEAR: begin
        if (clr_found) locked_d = clr_board;
        else           state_d  = GEN;
      end
      GAMEOVER: state_d = GAMEOVER;
      default:  state_d = NEWBOARD;
    endcase
  end

  // state and datapath registers, restart has priority everywhere
  always_ff @(posedge clka) begin
    if (restart) begin
      state_q  <= NEWBOARD;
      locked_q <= '0;
      mask_q   <= '0;
      x_q      <= XW'(SPAWN_X);
      y_q      <= '0;
      rot_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      mask_q   <= mask_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rot_q    <= rot_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef TETRIS_LINES_EN
  logic [LINES_W-1:0] lines_q, lines_d;

  // saturating count of rows removed in CLEAR
  always_comb begin
    lines_d = lines_q;
    if (state_q == CLEAR && clr_found && lines_q != '1) lines_d = lines_q + 1'b1;
  end

  // lines counter register
  always_ff @(posedge clka) begin
    if (restart) lines_q <= '0;
    else         lines_q <= lines_d;
  end

  assign lines = lines_q;
`else
  assign lines = '0;
`endif

  // display and status outputs
  always_comb begin
    case (state_q)
      NEWBOARD:   board_out = '0;
      GAMEOVER:   board_out = '1;
      MOVE, LAND: board_out = locked_q | piece_bits(mask_q, int'(x_q), int'(y_q));
      default:    board_out = locked_q;
    endcase
  end

  assign state      = state_q;
  assign move_ready = (state_q == MOVE) && (cnt_q != CW'(DROP_TICKS - 1));
  assign location_x = x_q;
  assign location_y = y_q;
  assign rotation   = rot_q;
  assign touched    = (state_q == LAND);
  assign game_over  = (state_q == GAMEOVER);

endmodule

// File: tb/tb_tetris_dp_param.sv
// Directed bench for tetris_dp_param at W=4 H=8 SPAWN_X=1 DROP_TICKS=8.
module tb_tetris_dp_param;
  logic        clka = 1'b0;
  logic        restart, start, move_valid;
  logic [1:0]  piece_in, move;
  logic        move_ready, touched, game_over;
  logic [2:0]  state;
  logic [31:0] board_out;
  logic [1:0]  location_x;
  logic [2:0]  location_y;
  logic [1:0]  rotation;
  logic [7:0]  lines;
  int total = 0;
  int bad   = 0;

  localparam logic [2:0] S_GEN = 3'b000, S_MOVE = 3'b001, S_LAND = 3'b010,
                         S_CLEAR = 3'b011, S_NEW = 3'b100, S_OVER = 3'b101;

  tetris_dp_param #(.W(4), .H(8), .SPAWN_X(1), .DROP_TICKS(8), .LINES_W(8)) dut (
    .clka(clka), .restart(restart), .start(start), .piece_in(piece_in),
    .move_valid(move_valid), .move(move), .move_ready(move_ready), .state(state),
    .board_out(board_out), .location_x(location_x), .location_y(location_y),
    .rotation(rotation), .touched(touched), .game_over(game_over), .lines(lines)
  );

  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // restart, start with piece p, end in the first MOVE cycle
  task automatic begin_game(input logic [1:0] p);
    move_valid = 1'b0;
    restart = 1'b1; tick(); restart = 1'b0;
    start = 1'b1; piece_in = p; tick(); start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    restart = 1'b1; start = 1'b0; move_valid = 1'b0; move = 2'd0; piece_in = 2'd0;
    tick(); tick();
    restart = 1'b0;
    total++; if (state !== S_NEW) begin bad++; $display("FAIL reset_state got=%0h exp=%0h", state, S_NEW); end
    total++; if (board_out !== 32'h0) begin bad++; $display("FAIL reset_board got=%0h exp=0", board_out); end
    total++; if ({location_x, location_y, rotation} !== {2'd1, 3'd0, 2'd0})
      begin bad++; $display("FAIL reset_pos got=%0h/%0h/%0h exp=1/0/0", location_x, location_y, rotation); end
    total++; if ({touched, move_ready, game_over} !== 3'b000)
      begin bad++; $display("FAIL reset_flags got=%b exp=000", {touched, move_ready, game_over}); end
    total++; if (lines !== 8'd0) begin bad++; $display("FAIL reset_lines got=%0d exp=0", lines); end
    tick();
    total++; if (state !== S_NEW) begin bad++; $display("FAIL newboard_hold got=%0h exp=%0h", state, S_NEW); end
  endtask

  task automatic test_spawn();
    start = 1'b1; piece_in = 2'd0; tick(); start = 1'b0;
    total++; if (state !== S_GEN) begin bad++; $display("FAIL spawn_gen got=%0h exp=%0h", state, S_GEN); end
    tick();
    total++; if (state !== S_MOVE) begin bad++; $display("FAIL spawn_move got=%0h exp=%0h", state, S_MOVE); end
    total++; if (board_out !== 32'h66) begin bad++; $display("FAIL spawn_board got=%0h exp=66", board_out); end
    total++; if ({location_x, location_y} !== {2'd1, 3'd0})
      begin bad++; $display("FAIL spawn_xy got=%0d,%0d exp=1,0", location_x, location_y); end
    total++; if (move_ready !== 1'b1) begin bad++; $display("FAIL spawn_ready got=%b exp=1", move_ready); end
  endtask

  task automatic test_left();
    move_valid = 1'b1; move = 2'd1; tick();
    total++; if (location_x !== 2'd0) begin bad++; $display("FAIL left_x got=%0d exp=0", location_x); end
    total++; if (board_out !== 32'h33) begin bad++; $display("FAIL left_board got=%0h exp=33", board_out); end
    tick(); move_valid = 1'b0;
    total++; if (location_x !== 2'd0) begin bad++; $display("FAIL left_block_x got=%0d exp=0", location_x); end
    total++; if (board_out !== 32'h33) begin bad++; $display("FAIL left_block_board got=%0h exp=33", board_out); end
  endtask

  task automatic test_drop_land();
    begin_game(2'd0);
    move_valid = 1'b1; move = 2'd0;
    repeat (6) tick();
    total++; if (location_y !== 3'd6) begin bad++; $display("FAIL drop_y got=%0d exp=6", location_y); end
    tick(); move_valid = 1'b0;
    total++; if (state !== S_LAND) begin bad++; $display("FAIL land_state got=%0h exp=%0h", state, S_LAND); end
    total++; if (touched !== 1'b1) begin bad++; $display("FAIL land_touched got=%b exp=1", touched); end
    tick();
    total++; if ({state, touched} !== {S_CLEAR, 1'b0})
      begin bad++; $display("FAIL land_clear got=%0h/%b exp=%0h/0", state, touched, S_CLEAR); end
    tick();
    total++; if (state !== S_GEN) begin bad++; $display("FAIL land_gen got=%0h exp=%0h", state, S_GEN); end
    total++; if (board_out !== 32'h6600_0000) begin bad++; $display("FAIL land_locked got=%0h exp=66000000", board_out); end
  endtask

  task automatic test_line_clear();
    int ncl;
    begin_game(2'd0);
    move_valid = 1'b1; move = 2'd1; tick();
    move = 2'd0; repeat (7) tick();
    move_valid = 1'b0;
    total++; if (state !== S_LAND) begin bad++; $display("FAIL lc_land1 got=%0h exp=%0h", state, S_LAND); end
    tick(); tick(); tick();
    total++; if ({state, board_out} !== {S_MOVE, 32'h3300_0066})
      begin bad++; $display("FAIL lc_second got=%0h/%0h exp=%0h/33000066", state, board_out, S_MOVE); end
    move_valid = 1'b1; move = 2'd2; tick();
    total++; if (location_x !== 2'd2) begin bad++; $display("FAIL lc_right got=%0d exp=2", location_x); end
    tick();
    total++; if (location_x !== 2'd2) begin bad++; $display("FAIL lc_right_edge got=%0d exp=2", location_x); end
    move = 2'd0; repeat (7) tick();
    move_valid = 1'b0;
    total++; if (state !== S_LAND) begin bad++; $display("FAIL lc_land2 got=%0h exp=%0h", state, S_LAND); end
    tick();
    ncl = 0;
    while (state == S_CLEAR && ncl < 20) begin ncl++; tick(); end
    total++; if (ncl !== 3) begin bad++; $display("FAIL lc_cycles got=%0d exp=3", ncl); end
    total++; if (state !== S_GEN) begin bad++; $display("FAIL lc_gen got=%0h exp=%0h", state, S_GEN); end
    total++; if (board_out !== 32'h0) begin bad++; $display("FAIL lc_board got=%0h exp=0", board_out); end
`ifdef TETRIS_LINES_EN
    total++; if (lines !== 8'd2) begin bad++; $display("FAIL lc_lines got=%0d exp=2", lines); end
`else
    total++; if (lines !== 8'd0) begin bad++; $display("FAIL lc_lines got=%0d exp=0", lines); end
`endif
  endtask

  task automatic test_game_over();
    int ngen, cyc;
    begin_game(2'd0);
    ngen = 0; cyc = 0;
    while (state != S_OVER && cyc < 2000) begin
      if (state == S_GEN) ngen++;
      cyc++; tick();
    end
    total++; if (state !== S_OVER) begin bad++; $display("FAIL go_state got=%0h exp=%0h", state, S_OVER); end
    total++; if (ngen !== 4) begin bad++; $display("FAIL go_spawns got=%0d exp=4", ngen); end
    total++; if (board_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL go_board got=%0h exp=ffffffff", board_out); end
    total++; if ({game_over, move_ready} !== 2'b10)
      begin bad++; $display("FAIL go_flags got=%b exp=10", {game_over, move_ready}); end
    move_valid = 1'b1; start = 1'b1; repeat (3) tick(); move_valid = 1'b0; start = 1'b0;
    total++; if (state !== S_OVER) begin bad++; $display("FAIL go_hold got=%0h exp=%0h", state, S_OVER); end
    restart = 1'b1; tick(); restart = 1'b0;
    total++; if ({state, board_out} !== {S_NEW, 32'h0})
      begin bad++; $display("FAIL go_restart got=%0h/%0h exp=%0h/0", state, board_out, S_NEW); end
  endtask

  task automatic test_rotate_gravity();
    begin_game(2'd2);
    total++; if (board_out !== 32'h26) begin bad++; $display("FAIL rg_spawn got=%0h exp=26", board_out); end
    repeat (7) tick();
    total++; if ({move_ready, location_y} !== {1'b0, 3'd0})
      begin bad++; $display("FAIL rg_grav_cycle got=%b/%0d exp=0/0", move_ready, location_y); end
    move_valid = 1'b1; move = 2'd1; tick(); move_valid = 1'b0;
    total++; if ({location_x, location_y} !== {2'd1, 3'd1})
      begin bad++; $display("FAIL rg_grav_y got=%0d,%0d exp=1,1", location_x, location_y); end
    total++; if (move_ready !== 1'b1) begin bad++; $display("FAIL rg_ready_back got=%b exp=1", move_ready); end
    move_valid = 1'b1; move = 2'd3; tick();
    total++; if ({rotation, board_out} !== {2'd1, 32'h460})
      begin bad++; $display("FAIL rg_rot1 got=%0d/%0h exp=1/460", rotation, board_out); end
    repeat (3) tick(); move_valid = 1'b0;
    total++; if ({rotation, board_out} !== {2'd0, 32'h260})
      begin bad++; $display("FAIL rg_rot_wrap got=%0d/%0h exp=0/260", rotation, board_out); end
    total++; if (lines !== 8'd0) begin bad++; $display("FAIL rg_lines got=%0d exp=0", lines); end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_left();
    test_drop_land();
    test_line_clear();
    test_game_over();
    test_rotate_gravity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
